// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU/FPGA requesters, the memory port and mem_bus_arbiter.
// slave = arbiter side, master = environment (requesters + memory) side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_err;
  logic [DATA_W-1:0] cpu_rdata;

  logic              fpga_req;
  logic              fpga_we;
  logic [ADDR_W-1:0] fpga_addr;
  logic [DATA_W-1:0] fpga_wdata;
  logic              fpga_ack;
  logic              fpga_err;
  logic [DATA_W-1:0] fpga_rdata;

  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  logic              busy;
  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  fpga_req, fpga_we, fpga_addr, fpga_wdata,
    input  mem_rdata, mem_done,
    output cpu_ack, cpu_err, cpu_rdata,
    output fpga_ack, fpga_err, fpga_rdata,
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output fpga_req, fpga_we, fpga_addr, fpga_wdata,
    output mem_rdata, mem_done,
    input  cpu_ack, cpu_err, cpu_rdata,
    input  fpga_ack, fpga_err, fpga_rdata,
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// CPU/FPGA arbiter for the single data-memory port: IDLE->ISSUE->WAIT->RESP sequencer with timeout.
// ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests; otherwise FPGA has fixed priority.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               nrst,
  mem_bus_arbiter_if.slave   bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic              r_owner;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_ren;
  logic              r_mem_wen;
  logic              r_cpu_ack;
  logic              r_fpga_ack;
  logic              r_cpu_err;
  logic              r_fpga_err;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_fpga_rdata;
  logic              r_busy;

  logic              w_any_req;
  logic              w_grant_fpga;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_timeout;
  logic              w_load_rdata;
  logic [DATA_W-1:0] w_resp_rdata;

  assign w_any_req = bus.cpu_req | bus.fpga_req;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention serve whoever was not served last; owner resets to FPGA so CPU goes first.
  assign w_grant_fpga = (bus.cpu_req & bus.fpga_req) ? ~r_owner : bus.fpga_req;
`else
  assign w_grant_fpga = bus.fpga_req;
`endif

  assign w_sel_we    = w_grant_fpga ? bus.fpga_we    : bus.cpu_we;
  assign w_sel_addr  = w_grant_fpga ? bus.fpga_addr  : bus.cpu_addr;
  assign w_sel_wdata = w_grant_fpga ? bus.fpga_wdata : bus.cpu_wdata;

  assign w_timeout    = (r_cnt == CNT_LAST);
  // A timed-out transaction clears the owner's read data; a completed write leaves it alone.
  assign w_load_rdata = ~bus.mem_done | ~r_we;
  assign w_resp_rdata = bus.mem_done ? bus.mem_rdata : '0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.mem_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_owner      <= 1'b1;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_ren    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_fpga_ack   <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_fpga_err   <= 1'b0;
      r_cpu_rdata  <= '0;
      r_fpga_rdata <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_mem_ren  <= 1'b0;
      r_mem_wen  <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_fpga_ack <= 1'b0;
      r_cpu_err  <= 1'b0;
      r_fpga_err <= 1'b0;
      r_busy     <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_grant_fpga;
            r_we        <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_ren   <= ~w_sel_we;
            r_mem_wen   <= w_sel_we;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (w_state_nxt == S_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cpu_ack  <= ~r_owner;
            r_fpga_ack <= r_owner;
            r_cpu_err  <= ~r_owner & ~bus.mem_done;
            r_fpga_err <= r_owner & ~bus.mem_done;
            if (w_load_rdata) begin
              if (r_owner) r_fpga_rdata <= w_resp_rdata;
              else         r_cpu_rdata  <= w_resp_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_ren    = r_mem_ren;
  assign bus.mem_wen    = r_mem_wen;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.cpu_err    = r_cpu_err;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.fpga_ack   = r_fpga_ack;
  assign bus.fpga_err   = r_fpga_err;
  assign bus.fpga_rdata = r_fpga_rdata;
  assign bus.busy       = r_busy;
  assign bus.owner      = r_owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected responses,
// an independent monitor pops and compares on every acknowledge.
module tb_mem_bus_arbiter;
  localparam int          AW = 32;
  localparam int          DW = 32;
  localparam int          TO = 15;
  localparam logic [31:0] K  = 32'hA5A5_0000;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  typedef struct packed {
    logic        fpga;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_cpu_rd  = '0;
  logic [31:0] m_fpga_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event not as required", name);
  endtask

  // Monitor: every acknowledge must match the oldest expected response.
  always @(negedge clk) begin
    if (bus.cpu_ack || bus.fpga_ack) begin
      if (bus.cpu_ack && bus.fpga_ack) fail("both_acks");
      else if (sb.size() == 0) fail("unexpected_ack");
      else begin
        mon_e = sb.pop_front();
        chk("ack_owner", 32'(bus.fpga_ack), 32'(mon_e.fpga));
        chk("ack_err", 32'(bus.fpga_ack ? bus.fpga_err : bus.cpu_err), 32'(mon_e.err));
        chk("other_err", 32'(bus.fpga_ack ? bus.cpu_err : bus.fpga_err), 32'(0));
        chk("ack_rdata", bus.fpga_ack ? bus.fpga_rdata : bus.cpu_rdata, mon_e.rd);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpu_ack"},  32'(bus.cpu_ack),  32'(0));
    chk({tag, "_fpga_ack"}, 32'(bus.fpga_ack), 32'(0));
    chk({tag, "_errs"},     32'({bus.cpu_err, bus.fpga_err}), 32'(0));
    chk({tag, "_strobes"},  32'({bus.mem_ren, bus.mem_wen}), 32'(0));
    chk({tag, "_busy"},     32'(bus.busy), 32'(0));
    chk({tag, "_mem_addr"}, bus.mem_addr,   32'(0));
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'(0));
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'(0));
    chk({tag, "_fpga_rdata"}, bus.fpga_rdata, 32'(0));
    chk({tag, "_owner"},    32'(bus.owner), 32'(1));
  endtask

  // dly = WAIT cycles before mem_done (0 = earliest); negative = memory never answers.
  task automatic txn(input bit fpga, input bit we, input logic [31:0] addr,
                     input logic [31:0] wd, input int dly, input logic [31:0] mrd,
                     input bit hold);
    logic [31:0] rd;
    int          cnt;
    int          exp_lat;
    bit          got;
    rd = fpga ? m_fpga_rd : m_cpu_rd;
    if (dly < 0) rd = '0;
    else if (!we) rd = mrd;
    if (fpga) m_fpga_rd = rd; else m_cpu_rd = rd;
    exp_lat = (dly < 0) ? 2 + TO : 3 + dly;
    sb.push_back('{fpga: fpga, err: (dly < 0), rd: rd});

    @(negedge clk);
    if (fpga) begin
      bus.fpga_req = 1'b1; bus.fpga_we = we; bus.fpga_addr = addr; bus.fpga_wdata = wd;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
    @(negedge clk);
    cnt = 1;
    chk("strobe_ren", 32'(bus.mem_ren), 32'(!we));
    chk("strobe_wen", 32'(bus.mem_wen), 32'(we));
    chk("grant_owner", 32'(bus.owner), 32'(fpga));
    chk("issue_addr", bus.mem_addr, addr);
    chk("issue_busy", 32'(bus.busy), 32'(1));
    got = 1'b0;
    while (!got && cnt < 100) begin
      @(negedge clk);
      cnt++;
      bus.mem_done = 1'b0;
      if (bus.cpu_ack || bus.fpga_ack) got = 1'b1;
      else begin
        chk("wait_no_strobe", 32'({bus.mem_ren, bus.mem_wen}), 32'(0));
        chk("wait_addr_stable", bus.mem_addr, addr);
        if (we) chk("wait_wdata_stable", bus.mem_wdata, wd);
        if (cnt - 2 == dly) begin
          bus.mem_done  = 1'b1;
          bus.mem_rdata = mrd;
        end
      end
    end
    if (!got) fail("ack_timeout");
    else chk("latency", 32'(cnt), 32'(exp_lat));
    if (!hold) begin
      if (fpga) bus.fpga_req = 1'b0; else bus.cpu_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit          f;
    int          acks;
    int          cyc;
    int          last;
    bit          do_done;

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.fpga_req = 0; bus.fpga_we = 0; bus.fpga_addr = '0; bus.fpga_wdata = '0;
    bus.mem_rdata = '0; bus.mem_done = 0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    nrst = 1'b1;

    txn(1'b0, 1'b0, 32'd220, 32'h0, 0, 32'h2A, 1'b0);
    txn(1'b1, 1'b1, 32'd260, 32'h03, 5, 32'hDEAD_BEEF, 1'b0);
    txn(1'b0, 1'b0, 32'd224, 32'h0, -1, 32'h0, 1'b0);
    txn(1'b0, 1'b0, 32'd228, 32'h0, 0, 32'h55, 1'b0);
    txn(1'b1, 1'b0, 32'd264, 32'h0, TO - 1, 32'h77, 1'b0);
    chk("cpu_rdata_held", bus.cpu_rdata, 32'h55);
    txn(1'b0, 1'b0, 32'd300, 32'h0, 0, 32'h11, 1'b1);
    txn(1'b0, 1'b0, 32'd304, 32'h0, 1, 32'h22, 1'b0);

    // Reset in the middle of WAIT: transaction is dropped, no acknowledge.
    @(negedge clk);
    bus.fpga_req = 1'b1; bus.fpga_we = 1'b0; bus.fpga_addr = 32'h300;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", 32'(bus.busy), 32'(1));
    nrst = 1'b0;
    bus.fpga_req = 1'b0;
    m_cpu_rd = '0; m_fpga_rd = '0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 32'(bus.busy), 32'(0));

    // Both masters requesting continuously for four transactions.
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      f = (i % 2) == 1;
`else
      f = 1'b1;
`endif
      rd = (f ? 32'h20 : 32'h10) ^ K;
      if (f) m_fpga_rd = rd; else m_cpu_rd = rd;
      sb.push_back('{fpga: f, err: 1'b0, rd: rd});
    end
    @(negedge clk);
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b0;  bus.cpu_addr = 32'h10;
    bus.fpga_req = 1'b1; bus.fpga_we = 1'b0; bus.fpga_addr = 32'h20;
    acks = 0; cyc = 0; last = -1; do_done = 1'b0;
    while (acks < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.mem_done = 1'b0;
      if (do_done) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = bus.mem_addr ^ K;
        do_done = 1'b0;
      end
      if (bus.mem_ren) do_done = 1'b1;
      if (bus.cpu_ack || bus.fpga_ack) begin
        acks++;
        if (last >= 0) chk("b2b_interval", 32'(cyc - last), 32'(4));
        last = cyc;
        if (acks == 4) begin
          bus.cpu_req = 1'b0;
          bus.fpga_req = 1'b0;
        end
      end
    end
    if (acks < 4) fail("contention_ack_count");
    bus.cpu_req = 1'b0;
    bus.fpga_req = 1'b0;

    txn(1'b0, 1'b1, 32'd5, 32'h99, 2, 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
